// File: rtl/keccak_pkg.sv
// Shared Keccak constants, output-stage word counts and the dump FSM state type.
package keccak_pkg;

    localparam int unsigned w             = 64;
    localparam int unsigned RATE_SHAKE128 = 1344;
    localparam int unsigned RATE_SHAKE256 = 1088;

    localparam logic [1:0] SHAKE256_MODE_VEC = 2'b01;

    localparam logic [4:0] RATE_WORDS_SHAKE128 = 5'd21;
    localparam logic [4:0] RATE_WORDS_SHAKE256 = 5'd17;

    typedef enum logic {DUMP_IDLE, DUMP_ACTIVE} dump_state_t;

    // Keep the low rem bits of a word; rem == 0 means the whole word is owed.
    function automatic logic [63:0] tail_mask(input logic [63:0] word, input logic [5:0] rem);
        logic [63:0] mask_v;
        if (rem == 6'd0) begin
            mask_v = {64{1'b1}};
        end else begin
            mask_v = (64'd1 << rem) - 64'd1;
        end
        return word & mask_v;
    endfunction

endpackage

// File: rtl/countern.sv
// Generic up-counter with synchronous clear (priority) and enable.
module countern #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             count_end
);

    logic [WIDTH-1:0] count_r;

    // Count register: clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count     = count_r;
    assign count_end = &count_r;

endmodule

// File: rtl/dump_datapath.sv
// Squeeze output stage: serializes one permuted rate block into W-bit words,
// trimming and tail-masking the final block to the remaining output size.
module dump_datapath
    import keccak_pkg::*;
#(
    parameter int W         = w,
    parameter int RATE      = RATE_SHAKE128,
    parameter int MAX_WORDS = RATE / W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RATE-1:0] rate_input,
    input  logic [1:0]      operation_mode_in,
    input  logic [31:0]     output_size_in,
    input  logic            last_block_in,
    input  logic            block_valid_in,
    output logic            block_ready_out,
    output logic [W-1:0]    data_out,
    output logic            data_valid_out,
    input  logic            data_ready_in,
    output logic            data_last_out
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_CNT = CNT_W'(2);

    dump_state_t      state_r, state_next_s;
    logic [RATE-1:0]  sreg_r;
    logic [CNT_W-1:0] nwords_r;
    logic             last_r;
    logic             fits_r;
    logic [5:0]       rem_r;
    logic             block_ready_r;
    logic             data_valid_r;
    logic             data_last_r;
    logic [W-1:0]     data_out_r;

    logic [CNT_W-1:0] word_cnt_s;
    logic             count_end_unused_s;
    logic             accept_s;
    logic             xfer_s;
    logic [CNT_W-1:0] bw_s;
    logic [32:0]      ceil_s;
    logic             fits_in_s;
    logic [CNT_W-1:0] nwords_in_s;
    logic             first_final_s;
    logic             last_word_s;
    logic             final_next_s;
    logic [W-1:0]     first_word_s;
    logic [W-1:0]     next_word_s;

    assign accept_s = block_valid_in && (state_r == DUMP_IDLE);
    assign xfer_s   = data_valid_r && data_ready_in;

    // Word counter: restarts on every accepted block, advances per transfer.
    countern #(.WIDTH(CNT_W)) u_word_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept_s),
        .enable    (xfer_s),
        .count     (word_cnt_s),
        .count_end (count_end_unused_s)
    );

    // Block sizing: 33-bit ceiling so sizes near 2^32 cannot wrap into a small count.
    always_comb begin
        bw_s          = (operation_mode_in == SHAKE256_MODE_VEC) ? CNT_W'(RATE_WORDS_SHAKE256)
                                                                 : CNT_W'(RATE_WORDS_SHAKE128);
        ceil_s        = ({1'b0, output_size_in} + 33'd63) >> 6;
        fits_in_s     = (ceil_s <= 33'(bw_s));
        if (!last_block_in) begin
            nwords_in_s = bw_s;
        end else if (fits_in_s) begin
            nwords_in_s = ceil_s[CNT_W-1:0];
        end else begin
            nwords_in_s = bw_s;
        end
        first_final_s = last_block_in && fits_in_s && (nwords_in_s == ONE_CNT);
        first_word_s  = rate_input[RATE-1 -: W];
        next_word_s   = sreg_r[RATE-1-W -: W];
        last_word_s   = (word_cnt_s == (nwords_r - ONE_CNT));
        final_next_s  = last_r && fits_r && ((word_cnt_s + TWO_CNT) == nwords_r);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DUMP_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a zero-word block is dropped without leaving IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DUMP_IDLE: begin
                if (accept_s && (nwords_in_s != '0)) begin
                    state_next_s = DUMP_ACTIVE;
                end else begin
                    state_next_s = DUMP_IDLE;
                end
            end
            DUMP_ACTIVE: begin
                if (xfer_s && last_word_s) begin
                    state_next_s = DUMP_IDLE;
                end else begin
                    state_next_s = DUMP_ACTIVE;
                end
            end
            default: state_next_s = DUMP_IDLE;
        endcase
    end

    // Datapath and registered stream outputs; the next word is pre-masked one cycle ahead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_r        <= '0;
            nwords_r      <= '0;
            last_r        <= 1'b0;
            fits_r        <= 1'b0;
            rem_r         <= 6'd0;
            block_ready_r <= 1'b1;
            data_valid_r  <= 1'b0;
            data_last_r   <= 1'b0;
            data_out_r    <= '0;
        end else begin
            case (state_r)
                DUMP_IDLE: begin
                    if (accept_s) begin
                        sreg_r   <= rate_input;
                        nwords_r <= nwords_in_s;
                        last_r   <= last_block_in;
                        fits_r   <= fits_in_s;
                        rem_r    <= output_size_in[5:0];
                        if (nwords_in_s != '0) begin
                            block_ready_r <= 1'b0;
                            data_valid_r  <= 1'b1;
                            data_last_r   <= first_final_s;
                            data_out_r    <= first_final_s ? tail_mask(first_word_s, output_size_in[5:0])
                                                           : first_word_s;
                        end
                    end
                end
                DUMP_ACTIVE: begin
                    if (xfer_s) begin
                        if (last_word_s) begin
                            block_ready_r <= 1'b1;
                            data_valid_r  <= 1'b0;
                            data_last_r   <= 1'b0;
                            data_out_r    <= '0;
                        end else begin
                            sreg_r      <= sreg_r << W;
                            data_last_r <= final_next_s;
                            data_out_r  <= final_next_s ? tail_mask(next_word_s, rem_r) : next_word_s;
                        end
                    end
                end
                default: begin
                    block_ready_r <= 1'b1;
                    data_valid_r  <= 1'b0;
                    data_last_r   <= 1'b0;
                    data_out_r    <= '0;
                end
            endcase
        end
    end

    assign block_ready_out = block_ready_r;
    assign data_valid_out  = data_valid_r;
    assign data_last_out   = data_last_r;
    assign data_out        = data_out_r;

endmodule

// File: tb/tb_dump_datapath.sv
// Self-checking bench for dump_datapath: directed scenarios plus randomized blocks
// compared against a word-list reference model.
module tb_dump_datapath;
    import keccak_pkg::*;

    localparam int RATE = 1344;

    logic            clk = 1'b0;
    logic            rst;
    logic [RATE-1:0] rate_input;
    logic [1:0]      operation_mode_in;
    logic [31:0]     output_size_in;
    logic            last_block_in;
    logic            block_valid_in;
    logic            block_ready_out;
    logic [63:0]     data_out;
    logic            data_valid_out;
    logic            data_ready_in;
    logic            data_last_out;

    always #5 clk = ~clk;

    dump_datapath dut (
        .clk               (clk),
        .rst               (rst),
        .rate_input        (rate_input),
        .operation_mode_in (operation_mode_in),
        .output_size_in    (output_size_in),
        .last_block_in     (last_block_in),
        .block_valid_in    (block_valid_in),
        .block_ready_out   (block_ready_out),
        .data_out          (data_out),
        .data_valid_out    (data_valid_out),
        .data_ready_in     (data_ready_in),
        .data_last_out     (data_last_out)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_xfer   = 0;
    int          ready_mode = 0;
    int          pat_idx  = 0;
    logic [63:0] exp_data_q[$];
    logic        exp_last_q[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: list of words the block must produce.
    task automatic model_block(input logic [RATE-1:0] rate, input logic [1:0] mode,
                               input logic [31:0] size, input logic last, output int n);
        int          bw;
        longint      c;
        bit          fits;
        logic [63:0] word;
        bit          is_last;
        bw   = (mode == SHAKE256_MODE_VEC) ? 17 : 21;
        c    = (longint'(size) + 63) / 64;
        fits = (c <= bw);
        if (!last)     n = bw;
        else if (fits) n = int'(c);
        else           n = bw;
        for (int k = 0; k < n; k++) begin
            word    = rate[RATE-1-64*k -: 64];
            is_last = last && fits && (k == n - 1);
            if (is_last && (size % 64 != 0)) word = word % (64'd1 << (size % 64));
            exp_data_q.push_back(word);
            exp_last_q.push_back(is_last);
        end
    endtask

    task automatic send_block(input logic [RATE-1:0] rate, input logic [1:0] mode,
                              input logic [31:0] size, input logic last);
        int i;
        int n;
        i = 0;
        @(negedge clk);
        while (!block_ready_out && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (i >= 200) check_val("ready_timeout", 64'd0, 64'd1);
        rate_input        = rate;
        operation_mode_in = mode;
        output_size_in    = size;
        last_block_in     = last;
        block_valid_in    = 1'b1;
        model_block(rate, mode, size, last, n);
        @(posedge clk);
        #1;
        block_valid_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while ((exp_data_q.size() != 0 || !block_ready_out) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [RATE-1:0] seq_block();
        logic [RATE-1:0] r;
        r = '0;
        for (int k = 0; k < 21; k++) r[RATE-1-64*k -: 64] = 64'h1000 + 64'(k);
        return r;
    endfunction

    function automatic logic [RATE-1:0] rand_block();
        logic [RATE-1:0] r;
        for (int k = 0; k < 42; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Downstream ready generator, changes just after each rising edge.
    initial begin
        data_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: data_ready_in = 1'($urandom_range(0, 1));
                2: begin
                    data_ready_in = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                    pat_idx++;
                end
                default: data_ready_in = 1'b1;
            endcase
        end
    end

    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = 64'd0;
    logic        prev_last  = 1'b0;

    // Stream monitor: scoreboard on transfers, stability while stalled.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("hold_valid", 64'(data_valid_out), 64'd1);
                check_val("hold_data", data_out, prev_data);
                check_val("hold_last", 64'(data_last_out), 64'(prev_last));
            end
            if (!data_valid_out) check_val("last_without_valid", 64'(data_last_out), 64'd0);
            if (data_valid_out && data_ready_in) begin
                if (exp_data_q.size() == 0) begin
                    check_val("unexpected_word", data_out, 64'd0);
                end else begin
                    check_val("word", data_out, exp_data_q.pop_front());
                    check_val("last", 64'(data_last_out), 64'(exp_last_q.pop_front()));
                end
                n_xfer++;
            end
            prev_stall = data_valid_out && !data_ready_in;
            prev_data  = data_out;
            prev_last  = data_last_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int i;
        logic [RATE-1:0] ones;
        rst               = 1'b1;
        rate_input        = '0;
        operation_mode_in = 2'b00;
        output_size_in    = 32'd0;
        last_block_in     = 1'b0;
        block_valid_in    = 1'b0;
        #1;
        check_val("rst_ready", 64'(block_ready_out), 64'd1);
        check_val("rst_valid", 64'(data_valid_out), 64'd0);
        check_val("rst_last", 64'(data_last_out), 64'd0);
        check_val("rst_data", data_out, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: full SHAKE128 block, no backpressure, exact cycle timing.
        ready_mode = 0;
        send_block(seq_block(), 2'b00, 32'd0, 1'b0);
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            check_val("t1_valid", 64'(data_valid_out), 64'd1);
        end
        @(negedge clk);
        check_val("t1_ready_after", 64'(block_ready_out), 64'd1);
        check_val("t1_valid_after", 64'(data_valid_out), 64'd0);
        check_val("t1_drained", 64'(exp_data_q.size()), 64'd0);

        // 2: SHAKE256 final block, 256 bits.
        base = n_xfer;
        send_block(rand_block(), SHAKE256_MODE_VEC, 32'd256, 1'b1);
        wait_done(100);
        check_val("t2_count", 64'(n_xfer - base), 64'd4);

        // 3: 100-bit tail on all-ones data.
        ones = '1;
        base = n_xfer;
        exp_data_q.delete();
        exp_last_q.delete();
        send_block(ones, 2'b00, 32'd100, 1'b1);
        check_val("t3_model_w1", exp_data_q[1], 64'h0000_000F_FFFF_FFFF);
        wait_done(100);
        check_val("t3_count", 64'(n_xfer - base), 64'd2);

        // 4: zero-size final block is swallowed.
        send_block(rand_block(), 2'b10, 32'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val("t4_valid", 64'(data_valid_out), 64'd0);
            check_val("t4_ready", 64'(block_ready_out), 64'd1);
        end

        // 5: backpressure pattern 1,0,0,1.
        ready_mode = 2;
        base = n_xfer;
        send_block(seq_block(), 2'b11, 32'd5, 1'b0);
        wait_done(300);
        check_val("t5_count", 64'(n_xfer - base), 64'd21);
        ready_mode = 0;

        // 6: asynchronous reset mid-block, then a fresh block from word 0.
        base = n_xfer;
        send_block(seq_block(), 2'b00, 32'd0, 1'b0);
        i = 0;
        while (n_xfer < base + 6 && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (i >= 100) check_val("t6_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("t6_ready", 64'(block_ready_out), 64'd1);
        check_val("t6_valid", 64'(data_valid_out), 64'd0);
        check_val("t6_last", 64'(data_last_out), 64'd0);
        check_val("t6_data", data_out, 64'd0);
        exp_data_q.delete();
        exp_last_q.delete();
        @(negedge clk);
        rst = 1'b0;
        base = n_xfer;
        send_block(seq_block(), 2'b00, 32'd0, 1'b0);
        wait_done(100);
        check_val("t6_count", 64'(n_xfer - base), 64'd21);

        // Randomized blocks.
        for (int b = 0; b < 40; b++) begin
            logic [31:0] size;
            ready_mode = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) size = $urandom;
            else                           size = 32'($urandom_range(0, 1500));
            send_block(rand_block(), 2'($urandom_range(0, 3)), size, 1'($urandom_range(0, 1)));
            wait_done(500);
        end
        ready_mode = 0;

        @(negedge clk);
        check_val("final_queue_empty", 64'(exp_data_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
